vx_csr_access_unit: RTL and testbench

- Sequencing front-end for the per-core CSR storage block; sits between the dispatch stage and that block.
- Accepts one CSR instruction (CSRRW/CSRRS/CSRRC and immediate forms) over a valid/ready handshake.
- Drives the storage block's read and write ports in a single access cycle, computes the read-modify-write value, and returns the old CSR value to commit over a second valid/ready handshake.

---
 rtl/vx_csr_access_unit_pkg.sv | 55 +++++
 rtl/vx_csr_access_unit_if.sv | 56 +++++
 rtl/vx_csr_access_unit.sv | 129 ++++++++++++
 tb/tb_vx_csr_access_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_access_unit_pkg.sv
// Shared types and helpers for the CSR access sequencer: widths, op encoding,
// captured request bundle and read-modify-write value computation.
package vx_csr_access_unit_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned NUM_THREADS   = 4;
    localparam int unsigned NW_WIDTH      = 2;
    localparam int unsigned UUID_WIDTH    = 44;
    localparam int unsigned CSR_ADDR_BITS = 12;
    localparam int unsigned RD_BITS       = 5;
    localparam int unsigned IMM_BITS      = 5;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        RW          = 2'd1,
        RS          = 2'd2,
        RC          = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]    uuid;
        logic [NW_WIDTH-1:0]      wid;
        logic [NUM_THREADS-1:0]   tmask;
        csr_op_e                  op;
        logic [CSR_ADDR_BITS-1:0] addr;
        logic                     use_imm;
        logic [IMM_BITS-1:0]      imm;
        logic [XLEN-1:0]          rs1_data;
        logic                     rs1_x0;
        logic [RD_BITS-1:0]       rd;
    } csr_req_t;

    function automatic logic [XLEN-1:0] csr_wdata(input csr_op_e op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] src);
        case (op)
            RW:      return src;
            RS:      return old | src;
            RC:      return old & ~src;
            default: return old;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] csr_src(input csr_req_t r);
        return r.use_imm ? XLEN'(r.imm) : r.rs1_data;
    endfunction

    // Set/clear with a zero source must not produce a write side effect
    function automatic logic csr_writes(input csr_req_t r);
        logic zero_src;
        zero_src = r.use_imm ? (r.imm == '0) : r.rs1_x0;
        return (r.op != CSR_OP_NONE) && !(((r.op == RS) || (r.op == RC)) && zero_src);
    endfunction

endpackage

// File: rtl/vx_csr_access_unit_if.sv
// Dispatch request, CSR storage port and commit response bundle for the CSR access unit.
interface vx_csr_access_unit_if;
    import vx_csr_access_unit_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [UUID_WIDTH-1:0]    in_uuid;
    logic [NW_WIDTH-1:0]      in_wid;
    logic [NUM_THREADS-1:0]   in_tmask;
    logic [1:0]               in_op;
    logic [CSR_ADDR_BITS-1:0] in_addr;
    logic                     in_use_imm;
    logic [IMM_BITS-1:0]      in_imm;
    logic [XLEN-1:0]          in_rs1_data;
    logic                     in_rs1_x0;
    logic [RD_BITS-1:0]       in_rd;

    logic                     csr_read_enable;
    logic [UUID_WIDTH-1:0]    csr_read_uuid;
    logic [NW_WIDTH-1:0]      csr_read_wid;
    logic [CSR_ADDR_BITS-1:0] csr_read_addr;
    logic [XLEN-1:0]          csr_read_data_ro;
    logic [XLEN-1:0]          csr_read_data_rw;
    logic                     csr_write_enable;
    logic [UUID_WIDTH-1:0]    csr_write_uuid;
    logic [NW_WIDTH-1:0]      csr_write_wid;
    logic [CSR_ADDR_BITS-1:0] csr_write_addr;
    logic [XLEN-1:0]          csr_write_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [UUID_WIDTH-1:0]    out_uuid;
    logic [NW_WIDTH-1:0]      out_wid;
    logic [NUM_THREADS-1:0]   out_tmask;
    logic [RD_BITS-1:0]       out_rd;
    logic [XLEN-1:0]          out_data;
    logic                     out_wb;
    logic                     out_illegal;

    modport slave (
        input  in_valid, in_uuid, in_wid, in_tmask, in_op, in_addr, in_use_imm, in_imm,
               in_rs1_data, in_rs1_x0, in_rd, csr_read_data_ro, csr_read_data_rw, out_ready,
        output in_ready, csr_read_enable, csr_read_uuid, csr_read_wid, csr_read_addr,
               csr_write_enable, csr_write_uuid, csr_write_wid, csr_write_addr, csr_write_data,
               out_valid, out_uuid, out_wid, out_tmask, out_rd, out_data, out_wb, out_illegal
    );

    modport master (
        output in_valid, in_uuid, in_wid, in_tmask, in_op, in_addr, in_use_imm, in_imm,
               in_rs1_data, in_rs1_x0, in_rd, csr_read_data_ro, csr_read_data_rw, out_ready,
        input  in_ready, csr_read_enable, csr_read_uuid, csr_read_wid, csr_read_addr,
               csr_write_enable, csr_write_uuid, csr_write_wid, csr_write_addr, csr_write_data,
               out_valid, out_uuid, out_wid, out_tmask, out_rd, out_data, out_wb, out_illegal
    );

endinterface

// File: rtl/vx_csr_access_unit.sv
// CSR access sequencer: IDLE -> ACCESS (one read/modify/write cycle) -> RESP.
// Define VX_CSR_RO_CHECK_EN to reject writes to the read-only CSR space (addr[11:10]==2'b11).
module vx_csr_access_unit
    import vx_csr_access_unit_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    vx_csr_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e          state;
    csr_req_t        req;
    csr_req_t        in_req;
    logic            in_ro;
    logic            req_ro;
    logic            in_wen;
    logic            req_illegal;
    logic [XLEN-1:0] old_val;

    logic            in_ready;
    logic            rd_en;
    logic            wr_en;
    logic            out_valid;
    logic [XLEN-1:0] out_data;
    logic            out_wb;
    logic            out_illegal;

    always_comb begin
        in_req          = '0;
        in_req.uuid     = bus.in_uuid;
        in_req.wid      = bus.in_wid;
        in_req.tmask    = bus.in_tmask;
        in_req.op       = csr_op_e'(bus.in_op);
        in_req.addr     = bus.in_addr;
        in_req.use_imm  = bus.in_use_imm;
        in_req.imm      = bus.in_imm;
        in_req.rs1_data = bus.in_rs1_data;
        in_req.rs1_x0   = bus.in_rs1_x0;
        in_req.rd       = bus.in_rd;
    end

`ifdef VX_CSR_RO_CHECK_EN
    assign in_ro  = (in_req.addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
    assign req_ro = (req.addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
`else
    assign in_ro  = 1'b0;
    assign req_ro = 1'b0;
`endif

    // Strobe decode is resolved at capture so both strobes come straight from flops
    assign in_wen      = csr_writes(in_req) && !in_ro;
    assign req_illegal = (req.op == CSR_OP_NONE) || (req_ro && csr_writes(req));
    assign old_val     = (req.op == CSR_OP_NONE) ? '0
                                                 : (bus.csr_read_data_ro | bus.csr_read_data_rw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req         <= '0;
            in_ready    <= 1'b1;
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_wb      <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        req      <= in_req;
                        in_ready <= 1'b0;
                        rd_en    <= (in_req.op != CSR_OP_NONE);
                        wr_en    <= in_wen;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rd_en       <= 1'b0;
                    wr_en       <= 1'b0;
                    out_valid   <= 1'b1;
                    out_data    <= old_val;
                    out_illegal <= req_illegal;
                    out_wb      <= (req.rd != '0) && !req_illegal;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.csr_read_enable  = rd_en;
    assign bus.csr_read_uuid    = req.uuid;
    assign bus.csr_read_wid     = req.wid;
    assign bus.csr_read_addr    = req.addr;
    // Write data depends on the same-cycle combinational read, so it cannot be a flop
    assign bus.csr_write_enable = wr_en;
    assign bus.csr_write_uuid   = req.uuid;
    assign bus.csr_write_wid    = req.wid;
    assign bus.csr_write_addr   = req.addr;
    assign bus.csr_write_data   = csr_wdata(req.op, old_val, csr_src(req));

    assign bus.out_valid   = out_valid;
    assign bus.out_uuid    = req.uuid;
    assign bus.out_wid     = req.wid;
    assign bus.out_tmask   = req.tmask;
    assign bus.out_rd      = req.rd;
    assign bus.out_data    = out_data;
    assign bus.out_wb      = out_wb;
    assign bus.out_illegal = out_illegal;

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// Directed self-checking bench for vx_csr_access_unit (follows VX_CSR_RO_CHECK_EN if defined).
module tb_vx_csr_access_unit;
    import vx_csr_access_unit_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    vx_csr_access_unit_if bus();

    vx_csr_access_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [11:0] addr, input logic use_imm,
                             input logic [4:0] imm, input logic [31:0] rs1, input logic x0,
                             input logic [4:0] rd, input logic [43:0] uuid, input logic [1:0] wid,
                             input logic [3:0] tmask);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_addr     = addr;
        bus.in_use_imm  = use_imm;
        bus.in_imm      = imm;
        bus.in_rs1_data = rs1;
        bus.in_rs1_x0   = x0;
        bus.in_rd       = rd;
        bus.in_uuid     = uuid;
        bus.in_wid      = wid;
        bus.in_tmask    = tmask;
    endtask

    // Issue one request, check the ACCESS cycle and the response; optionally complete the handshake
    task automatic run_req(input string tag, input logic [1:0] op, input logic [11:0] addr,
                           input logic use_imm, input logic [4:0] imm, input logic [31:0] rs1,
                           input logic x0, input logic [4:0] rd, input logic [31:0] ro_d,
                           input logic [31:0] rw_d, input logic exp_ren, input logic exp_wen,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                           input logic exp_ill, input logic exp_wb, input bit do_resp);
        @(negedge clk);
        bus.csr_read_data_ro = ro_d;
        bus.csr_read_data_rw = rw_d;
        drive_req(op, addr, use_imm, imm, rs1, x0, rd, 44'h123_4567_89AB, 2'd1, 4'b0111);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, ".in_ready_acc"}, 64'(bus.in_ready), 64'd0);
        check({tag, ".ren"}, 64'(bus.csr_read_enable), 64'(exp_ren));
        check({tag, ".wen"}, 64'(bus.csr_write_enable), 64'(exp_wen));
        check({tag, ".raddr"}, 64'(bus.csr_read_addr), 64'(addr));
        if (exp_wen) begin
            check({tag, ".wdata"}, 64'(bus.csr_write_data), 64'(exp_wdata));
            check({tag, ".waddr"}, 64'(bus.csr_write_addr), 64'(addr));
        end
        @(posedge clk); #1;
        check({tag, ".wen_resp"}, 64'(bus.csr_write_enable), 64'd0);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".out_data"}, 64'(bus.out_data), 64'(exp_data));
        check({tag, ".out_illegal"}, 64'(bus.out_illegal), 64'(exp_ill));
        check({tag, ".out_wb"}, 64'(bus.out_wb), 64'(exp_wb));
        check({tag, ".out_rd"}, 64'(bus.out_rd), 64'(rd));
        if (do_resp) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
            check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic ro_wen;
        logic ro_ill;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_req(2'd0, 12'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 44'h0, 2'd0, 4'd0);
        bus.in_valid = 1'b0;
        bus.csr_read_data_ro = '0;
        bus.csr_read_data_rw = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.ren", 64'(bus.csr_read_enable), 64'd0);
        check("rst.wen", 64'(bus.csr_write_enable), 64'd0);
        check("rst.out_data", 64'(bus.out_data), 64'd0);
        check("rst.out_uuid", 64'(bus.out_uuid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // CSRRW with uuid/wid pass-through on a wide uuid
        @(negedge clk);
        bus.csr_read_data_ro = 32'h0;
        bus.csr_read_data_rw = 32'h12;
        drive_req(2'd1, 12'h340, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd5, 44'hA5A_5A5A_5A5A, 2'd3, 4'b1010);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rw.ren", 64'(bus.csr_read_enable), 64'd1);
        check("rw.wen", 64'(bus.csr_write_enable), 64'd1);
        check("rw.wdata", 64'(bus.csr_write_data), 64'hDEAD_BEEF);
        check("rw.ruuid", 64'(bus.csr_read_uuid), 64'hA5A_5A5A_5A5A);
        check("rw.wwid", 64'(bus.csr_write_wid), 64'd3);
        @(posedge clk); #1;
        check("rw.out_valid", 64'(bus.out_valid), 64'd1);
        check("rw.out_data", 64'(bus.out_data), 64'h12);
        check("rw.out_uuid", 64'(bus.out_uuid), 64'hA5A_5A5A_5A5A);
        check("rw.out_wid", 64'(bus.out_wid), 64'd3);
        check("rw.out_tmask", 64'(bus.out_tmask), 64'b1010);
        check("rw.out_wb", 64'(bus.out_wb), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("rw.valid_drop", 64'(bus.out_valid), 64'd0);

        //        tag     op     addr   imm? imm    rs1           x0  rd    ro          rw          ren wen wdata         data          ill wb resp
        run_req("rsi0",  2'd2, 12'h001, 1, 5'd0,  32'hFFFF_FFFF, 0, 5'd7, 32'h0000_ABCD, 32'h0, 1, 0, 32'h0, 32'h0000_ABCD, 0, 1, 1);
        run_req("rc",    2'd3, 12'h300, 0, 5'd0,  32'h0000_000F, 0, 5'd0, 32'h0, 32'h0000_00FF, 1, 1, 32'h0000_00F0, 32'h0000_00FF, 0, 0, 1);
        run_req("rs",    2'd2, 12'h305, 0, 5'd0,  32'h0000_0100, 0, 5'd9, 32'h0, 32'h0000_000F, 1, 1, 32'h0000_010F, 32'h0000_000F, 0, 1, 1);
        run_req("rsx0",  2'd2, 12'h305, 0, 5'd0,  32'h0000_0100, 1, 5'd9, 32'h0, 32'h0000_000F, 1, 0, 32'h0, 32'h0000_000F, 0, 1, 1);
        run_req("rwi",   2'd1, 12'h341, 1, 5'h1F, 32'h5555_0000, 0, 5'd2, 32'h0, 32'h8000_0000, 1, 1, 32'h0000_001F, 32'h8000_0000, 0, 1, 1);
        run_req("rci",   2'd3, 12'h342, 1, 5'd5,  32'hFFFF_FFFF, 0, 5'd3, 32'h0000_00F0, 32'h0000_000F, 1, 1, 32'h0000_00FA, 32'h0000_00FF, 0, 1, 1);
        run_req("ill",   2'd0, 12'h340, 0, 5'd0,  32'h1234_5678, 0, 5'd3, 32'h0, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0, 1, 0, 1);

`ifdef VX_CSR_RO_CHECK_EN
        ro_wen = 1'b0;
        ro_ill = 1'b1;
`else
        ro_wen = 1'b1;
        ro_ill = 1'b0;
`endif
        run_req("ro",    2'd1, 12'hCC1, 0, 5'd0,  32'h0000_0042, 0, 5'd4, 32'h0000_0777, 32'h0, 1, ro_wen, 32'h0000_0042, 32'h0000_0777, ro_ill, !ro_ill, 1);
        run_req("ro_rd", 2'd2, 12'hCC1, 0, 5'd0,  32'h0000_0042, 1, 5'd4, 32'h0000_0777, 32'h0, 1, 0, 32'h0, 32'h0000_0777, 0, 1, 1);

        // Back-pressure: response held for 5 cycles while inputs and storage data change
        run_req("stall", 2'd1, 12'h340, 0, 5'd0, 32'h0000_00AA, 0, 5'd6, 32'h0, 32'h0000_0055, 1, 1, 32'h0000_00AA, 32'h0000_0055, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.csr_read_data_rw = 32'(i) + 32'h1000;
            drive_req(2'd2, 12'h111, 1'b0, 5'd0, 32'hFFFF, 1'b0, 5'd1, 44'h1, 2'd2, 4'b0001);
            @(posedge clk); #1;
            check($sformatf("stall%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("stall%0d.out_data", i), 64'(bus.out_data), 64'h55);
            check($sformatf("stall%0d.out_rd", i), 64'(bus.out_rd), 64'd6);
            check($sformatf("stall%0d.in_ready", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("stall%0d.ren", i), 64'(bus.csr_read_enable), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("stall.valid_drop", 64'(bus.out_valid), 64'd0);
        check("stall.in_ready", 64'(bus.in_ready), 64'd1);
        check("stall.no_early_accept", 64'(bus.csr_read_enable), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("next.ren", 64'(bus.csr_read_enable), 64'd1);
        check("next.raddr", 64'(bus.csr_read_addr), 64'h111);
        check("next.wen", 64'(bus.csr_write_enable), 64'd1);
        check("next.wdata", 64'(bus.csr_write_data), 64'h0000_FFFF | 64'(bus.csr_read_data_rw));
        @(posedge clk); #1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset pulse while in ACCESS drops the request
        @(negedge clk);
        drive_req(2'd1, 12'h340, 1'b0, 5'd0, 32'hCAFE_F00D, 1'b0, 5'd8, 44'h77, 2'd1, 4'b1111);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rstmid.wen_before", 64'(bus.csr_write_enable), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid.wen", 64'(bus.csr_write_enable), 64'd0);
        check("rstmid.ren", 64'(bus.csr_read_enable), 64'd0);
        check("rstmid.out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rstmid%0d.wen", i), 64'(bus.csr_write_enable), 64'd0);
            check($sformatf("rstmid%0d.out_valid", i), 64'(bus.out_valid), 64'd0);
            check($sformatf("rstmid%0d.in_ready", i), 64'(bus.in_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
